// File: rtl/vc_credit_sched.sv
// Credit-gated wormhole VC scheduler: per-VC round-robin packet lock, fixed VC priority, optional aging via RAVENOC_VC_AGING_EN.
// Zero-cycle grant, combinational from state and inputs; ready_i=0 holds the grant with no state change.
module vc_credit_sched #(
  parameter int NUM_VC         = 3,
  parameter int NUM_IN         = 4,
  parameter int CREDITS        = 2,
  parameter int HIGH_PRIO_ZERO = 1,
  parameter int AGE_LIMIT      = 8
) (
  input  logic                                  clk,
  input  logic                                  arst,
  input  logic [NUM_VC*NUM_IN-1:0]              req_i,
  input  logic [NUM_IN-1:0]                     tail_i,
  input  logic                                  ready_i,
  input  logic [NUM_VC-1:0]                     credit_ret_i,
  output logic [NUM_VC*NUM_IN-1:0]              grant_o,
  output logic                                  valid_o,
  output logic [$clog2(NUM_VC)-1:0]             vc_sel_o,
  output logic [NUM_VC*$clog2(CREDITS+1)-1:0]   credit_cnt_o,
  output logic                                  err_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int VW = $clog2(NUM_VC);

  typedef enum logic {IDLE, LOCKED} vc_state_t;

  vc_state_t         state_q [NUM_VC];
  vc_state_t         state_d [NUM_VC];
  logic [IW-1:0]     lock_q  [NUM_VC];
  logic [IW-1:0]     lock_d  [NUM_VC];
  logic [IW-1:0]     ptr_q   [NUM_VC];
  logic [IW-1:0]     ptr_d   [NUM_VC];
  logic [IW-1:0]     cand    [NUM_VC];
  logic [CW-1:0]     cred_q  [NUM_VC];
  logic [CW-1:0]     cred_d  [NUM_VC];
  logic              err_q, err_d;
  logic [NUM_VC-1:0] elig;
  logic              sel_found;
  int                sel_vc;
  logic              xfer;

`ifdef RAVENOC_VC_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age_q [NUM_VC];
  logic [AW-1:0] age_d [NUM_VC];
`else
  logic unused_age_limit;
  assign unused_age_limit = (AGE_LIMIT > 0);
`endif

  // Per-VC candidate input and eligibility, then VC selection.
  always_comb begin
    int  idx;
    logic aged;
    idx       = 0;
    aged      = 1'b0;
    elig      = '0;
    sel_found = 1'b0;
    sel_vc    = 0;
    for (int v = 0; v < NUM_VC; v++) begin
      cand[v] = lock_q[v];
      if (state_q[v] == LOCKED) begin
        elig[v] = req_i[v*NUM_IN + int'(lock_q[v])];
      end else begin
        for (int i = 0; i < NUM_IN; i++) begin
          idx = int'(ptr_q[v]) + i;
          if (idx >= NUM_IN) idx = idx - NUM_IN;
          if (!elig[v] && req_i[v*NUM_IN + idx]) begin
            elig[v] = 1'b1;
            cand[v] = IW'(idx);
          end
        end
      end
      if (cred_q[v] == '0) elig[v] = 1'b0;
    end
    if (HIGH_PRIO_ZERO != 0) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (!sel_found && elig[v]) begin
          sel_found = 1'b1;
          sel_vc    = v;
        end
      end
    end else begin
      for (int v = NUM_VC - 1; v >= 0; v--) begin
        if (!sel_found && elig[v]) begin
          sel_found = 1'b1;
          sel_vc    = v;
        end
      end
    end
`ifdef RAVENOC_VC_AGING_EN
    for (int v = 0; v < NUM_VC; v++) begin
      if (!aged && elig[v] && age_q[v] >= AW'(AGE_LIMIT)) begin
        aged      = 1'b1;
        sel_found = 1'b1;
        sel_vc    = v;
      end
    end
`endif
  end

  // Outputs are forced idle while reset is asserted.
  always_comb begin
    grant_o  = '0;
    valid_o  = arst & sel_found;
    vc_sel_o = '0;
    if (valid_o) begin
      grant_o[sel_vc*NUM_IN + int'(cand[sel_vc])] = 1'b1;
      vc_sel_o = VW'(sel_vc);
    end
  end

  assign xfer = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    err_d   = err_q;
    if (xfer) begin
      if (tail_i[cand[sel_vc]]) begin
        state_d[sel_vc] = IDLE;
        ptr_d[sel_vc]   = (int'(cand[sel_vc]) == NUM_IN - 1) ? '0 : cand[sel_vc] + 1'b1;
      end else begin
        state_d[sel_vc] = LOCKED;
        lock_d[sel_vc]  = cand[sel_vc];
      end
    end
    for (int v = 0; v < NUM_VC; v++) begin
      if (xfer && sel_vc == v && !credit_ret_i[v]) begin
        cred_d[v] = cred_q[v] - 1'b1;
      end else if (credit_ret_i[v] && !(xfer && sel_vc == v)) begin
        if (cred_q[v] == CW'(CREDITS)) err_d = 1'b1;
        else cred_d[v] = cred_q[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= IDLE;
        lock_q[v]  <= '0;
        ptr_q[v]   <= '0;
        cred_q[v]  <= CW'(CREDITS);
      end
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

`ifdef RAVENOC_VC_AGING_EN
  // Waiting only accrues on cycles where a grant could have transferred.
  always_comb begin
    age_d = age_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (xfer && sel_vc == v) age_d[v] = '0;
      else if (elig[v] && ready_i && age_q[v] < AW'(AGE_LIMIT)) age_d[v] = age_q[v] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int v = 0; v < NUM_VC; v++) age_q[v] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  always_comb begin
    credit_cnt_o = '0;
    for (int v = 0; v < NUM_VC; v++) credit_cnt_o[v*CW +: CW] = cred_q[v];
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_vc_credit_sched.sv
// Directed bench for vc_credit_sched at default parameters (3 VCs, 4 inputs, 2 credits).
module tb_vc_credit_sched;

  logic        clk;
  logic        arst;
  logic [11:0] req;
  logic [3:0]  tail;
  logic        ready;
  logic [2:0]  cret;
  logic [11:0] grant;
  logic        valid;
  logic [1:0]  vc_sel;
  logic [5:0]  ccnt;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  vc_credit_sched dut (
    .clk          (clk),
    .arst         (arst),
    .req_i        (req),
    .tail_i       (tail),
    .ready_i      (ready),
    .credit_ret_i (cret),
    .grant_o      (grant),
    .valid_o      (valid),
    .vc_sel_o     (vc_sel),
    .credit_cnt_o (ccnt),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset;
    arst = 1'b0; req = '0; tail = '0; ready = 1'b0; cret = '0;
    #2;
    arst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    arst = 1'b0; req = '1; tail = '0; ready = 1'b1; cret = '0;
    @(posedge clk); #1;
    n_cmp++; if (grant !== 12'h000) begin n_fail++; $display("FAIL reset_grant got=%h exp=%h", grant, 12'h000); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (vc_sel !== 2'd0) begin n_fail++; $display("FAIL reset_vc_sel got=%0d exp=0", vc_sel); end
    n_cmp++; if (ccnt !== 6'b101010) begin n_fail++; $display("FAIL reset_credits got=%b exp=101010", ccnt); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    req = '0;
    arst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    apply_reset();
    req = 12'h001; tail = 4'b0001; ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== 12'h001) begin n_fail++; $display("FAIL single_grant got=%h exp=%h", grant, 12'h001); end
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", valid); end
    @(posedge clk); #1;
    n_cmp++; if (ccnt[1:0] !== 2'd1) begin n_fail++; $display("FAIL single_credit got=%0d exp=1", ccnt[1:0]); end
    req = '0; cret = 3'b001;
    @(posedge clk); #1;
    cret = '0;
    n_cmp++; if (ccnt !== 6'b101010) begin n_fail++; $display("FAIL single_credit_ret got=%b exp=101010", ccnt); end
  endtask

  task automatic test_wormhole;
    int exp_in;
    apply_reset();
    ready = 1'b1; cret = 3'b001;
    for (int k = 0; k < 6; k++) begin
      exp_in = k / 3;
      req  = (k < 3) ? 12'h003 : 12'h002;
      tail = (k % 3 == 2) ? (4'b0001 << exp_in) : 4'b0000;
      @(negedge clk);
      n_cmp++;
      if (grant !== (12'h001 << exp_in)) begin
        n_fail++; $display("FAIL wormhole_grant cycle=%0d got=%h exp=%h", k, grant, 12'h001 << exp_in);
      end
      @(posedge clk); #1;
    end
    req = '0; tail = '0; cret = '0;
    n_cmp++; if (ccnt !== 6'b101010) begin n_fail++; $display("FAIL wormhole_credits got=%b exp=101010", ccnt); end
  endtask

  task automatic test_vc_prio;
    logic [11:0] exp_g [5];
    logic [1:0]  exp_s [5];
    exp_g[0] = 12'h001; exp_g[1] = 12'h001; exp_g[2] = 12'h100; exp_g[3] = 12'h100; exp_g[4] = 12'h000;
    exp_s[0] = 2'd0;    exp_s[1] = 2'd0;    exp_s[2] = 2'd2;    exp_s[3] = 2'd2;    exp_s[4] = 2'd0;
    apply_reset();
    req = 12'h101; tail = 4'b0001; ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (grant !== exp_g[k]) begin n_fail++; $display("FAIL prio_grant cycle=%0d got=%h exp=%h", k, grant, exp_g[k]); end
      n_cmp++; if (vc_sel !== exp_s[k]) begin n_fail++; $display("FAIL prio_vc_sel cycle=%0d got=%0d exp=%0d", k, vc_sel, exp_s[k]); end
      @(posedge clk); #1;
    end
    req = '0; tail = '0;
    n_cmp++; if (ccnt !== 6'b001000) begin n_fail++; $display("FAIL prio_credits got=%b exp=001000", ccnt); end
  endtask

  task automatic test_ready_low;
    apply_reset();
    req = 12'h001; tail = 4'b0000; ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (grant !== 12'h001) begin n_fail++; $display("FAIL stall_grant got=%h exp=%h", grant, 12'h001); end
    @(posedge clk); #1;
    n_cmp++; if (ccnt !== 6'b101010) begin n_fail++; $display("FAIL stall_credits got=%b exp=101010", ccnt); end
    req = 12'h002;
    @(negedge clk);
    n_cmp++; if (grant !== 12'h002) begin n_fail++; $display("FAIL stall_no_lock got=%h exp=%h", grant, 12'h002); end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_overflow;
    apply_reset();
    cret = 3'b010;
    @(posedge clk); #1;
    cret = '0;
    n_cmp++; if (ccnt !== 6'b101010) begin n_fail++; $display("FAIL overflow_credits got=%b exp=101010", ccnt); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_err got=%b exp=1", err); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got=%b exp=1", err); end
  endtask

  task automatic test_lock_zero_credit_and_reset;
    apply_reset();
    ready = 1'b1; req = 12'h004; tail = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (ccnt[1:0] !== 2'd0) begin n_fail++; $display("FAIL lock_credit_drain got=%0d exp=0", ccnt[1:0]); end
    req = 12'h005;
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL zero_credit_valid got=%b exp=0", valid); end
    cret = 3'b001;
    @(posedge clk); #1;
    cret = '0; req = 12'h001;
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL lock_retained got=%b exp=0", valid); end
    req = 12'h005;
    #1;
    n_cmp++; if (grant !== 12'h004) begin n_fail++; $display("FAIL lock_resume got=%h exp=%h", grant, 12'h004); end
    arst = 1'b0;
    #1;
    n_cmp++; if (grant !== 12'h000) begin n_fail++; $display("FAIL midreset_grant got=%h exp=%h", grant, 12'h000); end
    arst = 1'b1; req = 12'h001;
    #1;
    n_cmp++; if (grant !== 12'h001) begin n_fail++; $display("FAIL midreset_unlock got=%h exp=%h", grant, 12'h001); end
    n_cmp++; if (ccnt !== 6'b101010) begin n_fail++; $display("FAIL midreset_credits got=%b exp=101010", ccnt); end
    req = '0; ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_aging;
    logic [1:0] exp_s;
    apply_reset();
    req = 12'h011; tail = 4'b0001; ready = 1'b1; cret = 3'b011;
    for (int k = 1; k <= 10; k++) begin
`ifdef RAVENOC_VC_AGING_EN
      exp_s = (k == 9) ? 2'd1 : 2'd0;
`else
      exp_s = 2'd0;
`endif
      @(negedge clk);
      n_cmp++; if (vc_sel !== exp_s) begin n_fail++; $display("FAIL aging_vc_sel cycle=%0d got=%0d exp=%0d", k, vc_sel, exp_s); end
      @(posedge clk); #1;
    end
    req = '0; tail = '0; cret = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wormhole();
    test_vc_prio();
    test_ready_low();
    test_overflow();
    test_lock_zero_credit_and_reset();
    test_aging();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
